mul_div_unit: RTL and testbench

//  Iterative multiply/divide unit in the execute stage, beside the ALU. Takes the same

---
 rtl/mul_div_unit.sv | 153 +++++++++++++++
 tb/tb_mul_div_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers and MTHI/MTLO writes.
// Latency: WIDTH+1 edges from start to done; busy asserted for that whole window.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             hi_we,
    input  logic             lo_we,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t               state;
    logic [CW-1:0]        count;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     opnd;
    logic                 is_div;
    logic                 neg_res;
    logic                 neg_rem;
    logic                 dbz_pend;

    logic                 signed_op;
    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH:0]       rem_diff;
    logic [2*WIDTH-1:0]   acc_step;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;

    assign signed_op = ~op[0];
    assign abs_a     = (signed_op && srcA[WIDTH-1]) ? -srcA : srcA;
    assign abs_b     = (signed_op && srcB[WIDTH-1]) ? -srcB : srcB;

    // Multiply keeps the multiplier in the low half and shifts it out as product
    // bits arrive; divide shifts dividend bits from the low half into the remainder.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        rem_sh   = acc[2*WIDTH-1:WIDTH-1];
        rem_diff = rem_sh - {1'b0, opnd};
        acc_step = acc;
        if (is_div) begin
            if (!rem_diff[WIDTH])
                acc_step = {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc_step = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            if (acc[0])
                acc_step = {mul_sum, acc[WIDTH-1:1]};
            else
                acc_step = {1'b0, acc[2*WIDTH-1:1]};
        end
    end

    // A zero divisor leaves remainder = |dividend|, so the remainder sign fix
    // restores the original dividend; only the quotient needs forcing.
    always_comb begin
        prod_fix = neg_res ? -acc : acc;
        quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        if (dbz_pend)
            quo_fix = '1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            acc         <= '0;
            opnd        <= '0;
            is_div      <= 1'b0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            dbz_pend    <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= CALC;
                        busy     <= 1'b1;
                        count    <= '0;
                        is_div   <= op[1];
                        neg_res  <= signed_op & (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
                        neg_rem  <= signed_op & srcA[WIDTH-1];
                        dbz_pend <= op[1] & (srcB == '0);
                        if (op[1]) begin
                            acc  <= {{WIDTH{1'b0}}, abs_a};
                            opnd <= abs_b;
                        end else begin
                            acc  <= {{WIDTH{1'b0}}, abs_b};
                            opnd <= abs_a;
                        end
                    end else begin
                        if (hi_we)
                            hi <= srcA;
                        if (lo_we)
                            lo <= srcA;
                    end
                end
                CALC: begin
                    acc   <= acc_step;
                    count <= count + 1'b1;
                    if (count == LAST)
                        state <= FIX;
                end
                FIX: begin
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    div_by_zero <= is_div & dbz_pend;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed vector table, random ops against an arithmetic model,
// and hand sequences for mid-op start, MTHI/MTLO, and async reset.
module tb_mul_div_unit;

    localparam int W = 32;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  srcA;
    logic [W-1:0]  srcB;
    logic          hi_we;
    logic          lo_we;
    logic          busy;
    logic          done;
    logic          div_by_zero;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int total;
    int bad;
    logic [W-1:0] prev_hi;
    logic [W-1:0] prev_lo;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .srcA(srcA), .srcB(srcB), .hi_we(hi_we), .lo_we(lo_we),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] ehi;
        logic [W-1:0] elo;
        logic         edbz;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Results from the arithmetic definitions, using 64-bit integer math.
    function automatic void model(input logic [1:0] mop, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] h,
                                  output logic [W-1:0] l, output logic d);
        longint sa, sb, p, q, r;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        d  = 1'b0;
        h  = '0;
        l  = '0;
        case (mop)
            2'b00: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
            2'b01: begin up = ua * ub; h = up[63:32]; l = up[31:0]; end
            default: begin
                if (b == 0) begin
                    d = 1'b1; l = '1; h = a;
                end else if (mop == 2'b10) begin
                    q = sa / sb; r = sa % sb;
                    l = q[31:0]; h = r[31:0];
                end else begin
                    up = ua / ub; l = up[31:0];
                    up = ua % ub; h = up[31:0];
                end
            end
        endcase
    endfunction

    task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start = 1'b1; op = o; srcA = a; srcB = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 2'($urandom);
        srcA  = $urandom;
        srcB  = $urandom;
    endtask

    // Waits for done with a cycle budget; returns edges seen after the start edge.
    task automatic wait_done(output int cyc, output int busy_gaps);
        cyc = 0;
        busy_gaps = 0;
        while (cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) break;
            if (!busy) busy_gaps++;
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] ehi,
                          input logic [W-1:0] elo, input logic edbz);
        int cyc, gaps;
        launch(o, a, b);
        chk({name, ".busy_rise"}, busy, 1);
        chk({name, ".hold"}, {hi, lo}, {prev_hi, prev_lo});
        wait_done(cyc, gaps);
        chk({name, ".latency"}, cyc, W + 1);
        chk({name, ".busy_gaps"}, gaps, 0);
        chk({name, ".busy_at_done"}, busy, 0);
        chk({name, ".hi"}, hi, ehi);
        chk({name, ".lo"}, lo, elo);
        chk({name, ".dbz"}, div_by_zero, edbz);
        prev_hi = ehi;
        prev_lo = elo;
        @(posedge clk);
        #1;
        chk({name, ".done_pulse"}, {done, div_by_zero}, 0);
        chk({name, ".after"}, {hi, lo}, {prev_hi, prev_lo});
    endtask

    vec_t vecs[8];

    initial begin
        int cyc, gaps;
        logic [1:0]   rop;
        logic [W-1:0] ra, rb, mh, ml;
        logic         md;
        logic [W-1:0] edge_vals[5];

        total = 0; bad = 0;
        prev_hi = '0; prev_lo = '0;
        rst_n = 1'b0; start = 1'b0; op = 2'b00; srcA = '0; srcB = '0;
        hi_we = 1'b0; lo_we = 1'b0;

        vecs[0] = '{2'b00, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0};
        vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
        vecs[2] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[3] = '{2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[4] = '{2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0};
        vecs[5] = '{2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1};
        vecs[6] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0};
        vecs[7] = '{2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0};

        #12;
        chk("reset.outs", {busy, done, div_by_zero}, 0);
        chk("reset.hilo", {hi, lo}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].ehi, vecs[i].elo, vecs[i].edbz);

        edge_vals[0] = 32'h0; edge_vals[1] = 32'h1; edge_vals[2] = 32'hFFFF_FFFF;
        edge_vals[3] = 32'h8000_0000; edge_vals[4] = 32'h7FFF_FFFF;
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom);
            ra  = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom;
            if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(8, 28);
            model(rop, ra, rb, mh, ml, md);
            run_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, mh, ml, md);
        end

        // Second start and MTHI while busy must be ignored.
        launch(2'b00, 32'd7, 32'd6);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; op = 2'b00; srcA = 32'd2; srcB = 32'd2; hi_we = 1'b1; lo_we = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        chk("midop.busy", busy, 1);
        chk("midop.hold", {hi, lo}, {prev_hi, prev_lo});
        wait_done(cyc, gaps);
        chk("midop.latency", cyc, W + 1 - 5);
        chk("midop.result", {hi, lo}, {32'd0, 32'd42});
        prev_hi = 32'd0; prev_lo = 32'd42;
        @(posedge clk);

        @(negedge clk);
        lo_we = 1'b1; srcA = 32'h1234;
        @(posedge clk);
        #1;
        lo_we = 1'b0;
        chk("mtlo", {hi, lo}, {32'd0, 32'h1234});
        @(negedge clk);
        hi_we = 1'b1; lo_we = 1'b1; srcA = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        hi_we = 1'b0; lo_we = 1'b0;
        chk("mthi_mtlo", {hi, lo}, {32'hCAFE_F00D, 32'hCAFE_F00D});
        prev_hi = 32'hCAFE_F00D; prev_lo = 32'hCAFE_F00D;

        // Start wins over a same-edge move-to write.
        @(negedge clk);
        start = 1'b1; op = 2'b01; srcA = 32'd5; srcB = 32'd9; hi_we = 1'b1; lo_we = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        chk("start_wins.hold", {hi, lo}, {prev_hi, prev_lo});
        wait_done(cyc, gaps);
        chk("start_wins.latency", cyc, W + 1);
        chk("start_wins.result", {hi, lo}, {32'd0, 32'd45});
        prev_hi = 32'd0; prev_lo = 32'd45;
        @(posedge clk);

        // Async reset in the middle of a divide.
        launch(2'b10, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.outs", {busy, done, div_by_zero}, 0);
        chk("arst.hilo", {hi, lo}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        prev_hi = '0; prev_lo = '0;
        repeat (W + 4) @(posedge clk);
        #1;
        chk("arst.no_result", {done, hi, lo}, 0);
        run_op("post_reset_multu", 2'b01, 32'd3, 32'd3, 32'd0, 32'd9, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
